// File: rtl/abc_sweeper.sv
// abc_sweeper: steps {a,b,c} through 000..111 for the downstream 3-input
// function block, holding each vector DWELL cycles, samples f at the end of
// each hold into an 8-bit truth table, and pulses done when the sweep ends.
//
// Optional feature macro: ABC_SWEEP_CHECK_EN (adds expected/match/mismatch_cnt)
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start         sweep request, ignored while busy
//   a, b, c       vector driven to the function block ({a,b,c} = index)
//   f             function block output
//   busy          sweep in progress
//   done          one-cycle pulse on sweep completion
//   tt[7:0]       truth table, tt[i] = f sampled while {a,b,c} = i
//   expected[7:0] reference table                  (ABC_SWEEP_CHECK_EN only)
//   match         tt equals expected                (ABC_SWEEP_CHECK_EN only)
//   mismatch_cnt  popcount(tt ^ expected)           (ABC_SWEEP_CHECK_EN only)
module abc_sweeper #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = $clog2(DWELL + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt
`ifdef ABC_SWEEP_CHECK_EN
  ,
  input  logic [7:0] expected,
  output logic       match,
  output logic [3:0] mismatch_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tt_d;
  logic             busy_d, done_d;
  logic             dwell_end_c;
  logic [7:0]       tt_final_c;

  assign {a, b, c} = idx_q;
  assign dwell_end_c = (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tt      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt      <= tt_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tt_d       = tt;
    busy_d     = busy;
    done_d     = 1'b0;
    // Table with the current sample merged in, used on the end of a dwell
    tt_final_c         = tt;
    tt_final_c[idx_q]  = f;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          idx_d   = '0;
          cnt_d   = '0;
          tt_d    = '0;
          busy_d  = 1'b1;
        end
      end
      SWEEP: begin
        if (dwell_end_c) begin
          tt_d  = tt_final_c;
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ABC_SWEEP_CHECK_EN
  logic accept_c;
  logic finish_c;
  logic [3:0] diff_cnt_c;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  assign accept_c   = (state_q == IDLE) && start;
  assign finish_c   = (state_q == SWEEP) && dwell_end_c && (idx_q == 3'd7);
  assign diff_cnt_c = popcount8(tt_final_c ^ expected);

  // Compare against the reference only on the completion edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match        <= 1'b0;
      mismatch_cnt <= '0;
    end else if (accept_c) begin
      match        <= 1'b0;
      mismatch_cnt <= '0;
    end else if (finish_c) begin
      match        <= (diff_cnt_c == 4'd0);
      mismatch_cnt <= diff_cnt_c;
    end
  end
`endif

endmodule

// File: tb/tb_abc_sweeper.sv
// Directed bench for abc_sweeper: DWELL=4 instance (a) with selectable f
// source (fred / constant 1 / constant 0), plus a DWELL=1 instance (b).
module tb_abc_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start_a, start_b;
  logic       a_a, b_a, c_a, f_a, busy_a, done_a;
  logic       a_b, b_b, c_b, f_b, busy_b, done_b;
  logic [7:0] tt_a, tt_b;
  logic [1:0] f_mode;
  int         total;
  int         bad;
`ifdef ABC_SWEEP_CHECK_EN
  logic [7:0] exp_a, exp_b;
  logic       match_a, match_b;
  logic [3:0] mcnt_a, mcnt_b;
`endif

  // Reference fred: truth table 8'hCE over index {a,b,c}
  function automatic logic fred(input logic x, input logic y, input logic z);
    return y | (~x & z);
  endfunction

  assign f_a = (f_mode == 2'd0) ? fred(a_a, b_a, c_a) : (f_mode == 2'd1);
  assign f_b = fred(a_b, b_b, c_b);

  abc_sweeper #(.DWELL(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .a(a_a), .b(b_a), .c(c_a), .f(f_a),
    .busy(busy_a), .done(done_a), .tt(tt_a)
`ifdef ABC_SWEEP_CHECK_EN
    , .expected(exp_a), .match(match_a), .mismatch_cnt(mcnt_a)
`endif
  );

  abc_sweeper #(.DWELL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .a(a_b), .b(b_b), .c(c_b), .f(f_b),
    .busy(busy_b), .done(done_b), .tt(tt_b)
`ifdef ABC_SWEEP_CHECK_EN
    , .expected(exp_b), .match(match_b), .mismatch_cnt(mcnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start_a for the accepting edge E0 and check the cleared state
  task automatic accept_a();
    @(negedge clk);
    start_a = 1'b1;
    tick();
    chk("acc_busy", 32'(busy_a), 32'd1);
    chk("acc_done", 32'(done_a), 32'd0);
    chk("acc_tt", 32'(tt_a), 32'd0);
    chk("acc_abc", 32'({a_a, b_a, c_a}), 32'd0);
  endtask

  // Edges E1..E32 of a DWELL=4 sweep; optional stray start pulse and
  // start held high into the completion edge
  task automatic sweep_a(input logic [7:0] exp_tt, input int pulse_at, input bit hold_end);
    logic [8:0] m;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      start_a = (n == pulse_at) || (hold_end && n == 32);
      tick();
      if (n < 32) begin
        m = (9'd1 << (n / 4)) - 9'd1;
        chk("sw_abc", 32'({a_a, b_a, c_a}), 32'(n / 4));
        chk("sw_busy", 32'(busy_a), 32'd1);
        chk("sw_done", 32'(done_a), 32'd0);
        chk("sw_tt", 32'(tt_a), 32'(exp_tt & m[7:0]));
      end else begin
        chk("end_done", 32'(done_a), 32'd1);
        chk("end_busy", 32'(busy_a), 32'd0);
        chk("end_tt", 32'(tt_a), 32'(exp_tt));
        chk("end_abc", 32'({a_a, b_a, c_a}), 32'd0);
      end
    end
  endtask

  // One edge after completion with start low: pulse gone, table held
  task automatic finish_a(input logic [7:0] exp_tt);
    @(negedge clk);
    start_a = 1'b0;
    tick();
    chk("post_done", 32'(done_a), 32'd0);
    chk("post_busy", 32'(busy_a), 32'd0);
    chk("post_tt", 32'(tt_a), 32'(exp_tt));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    f_mode  = 2'd0;
`ifdef ABC_SWEEP_CHECK_EN
    exp_a = 8'hCE;
    exp_b = 8'hCE;
`endif
    #12;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_tt", 32'(tt_a), 32'd0);
    chk("rst_abc", 32'({a_a, b_a, c_a}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy_a), 32'd0);

    // Full sweep against fred
    f_mode = 2'd0;
    accept_a();
    sweep_a(8'hCE, 0, 1'b0);
`ifdef ABC_SWEEP_CHECK_EN
    chk("chk_match_ce", 32'(match_a), 32'd1);
    chk("chk_cnt_ce", 32'(mcnt_a), 32'd0);
`endif
    finish_a(8'hCE);

    // Constant f
    f_mode = 2'd1;
    accept_a();
    sweep_a(8'hFF, 0, 1'b0);
    finish_a(8'hFF);
    f_mode = 2'd2;
    accept_a();
    sweep_a(8'h00, 0, 1'b0);
    finish_a(8'h00);

    // Start while busy, then start held through completion
    f_mode = 2'd1;
    accept_a();
    sweep_a(8'hFF, 5, 1'b1);
    f_mode = 2'd0;
    accept_a();
    sweep_a(8'hCE, 0, 1'b0);
    finish_a(8'hCE);

    // Reset mid-sweep at E10
    accept_a();
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      tick();
    end
    chk("pre_rst_tt", 32'(tt_a), 32'h02);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_tt", 32'(tt_a), 32'd0);
    chk("mid_rst_abc", 32'({a_a, b_a, c_a}), 32'd0);
    chk("mid_rst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("no_done_after_rst", 32'(done_a), 32'd0);
    end
    accept_a();
    sweep_a(8'hCE, 0, 1'b0);
    finish_a(8'hCE);

    // Minimum dwell
    @(negedge clk);
    start_b = 1'b1;
    tick();
    chk("d1_acc_busy", 32'(busy_b), 32'd1);
    chk("d1_acc_abc", 32'({a_b, b_b, c_b}), 32'd0);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      start_b = 1'b0;
      tick();
      if (n < 8) begin
        chk("d1_abc", 32'({a_b, b_b, c_b}), 32'(n));
        chk("d1_done", 32'(done_b), 32'd0);
      end else begin
        chk("d1_end_done", 32'(done_b), 32'd1);
        chk("d1_end_busy", 32'(busy_b), 32'd0);
        chk("d1_end_tt", 32'(tt_b), 32'hCE);
      end
    end
    tick();
    chk("d1_post_done", 32'(done_b), 32'd0);

`ifdef ABC_SWEEP_CHECK_EN
    // Reference mismatching in every bit
    exp_a = 8'h31;
    accept_a();
    chk("chk_clr_match", 32'(match_a), 32'd0);
    chk("chk_clr_cnt", 32'(mcnt_a), 32'd0);
    sweep_a(8'hCE, 0, 1'b0);
    chk("chk_match_31", 32'(match_a), 32'd0);
    chk("chk_cnt_31", 32'(mcnt_a), 32'd8);
    finish_a(8'hCE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
